// File: rtl/decoupled_req_fifo.sv
// Elastic per-requestor buffer upstream of the round-robin arbiter.
// Valid/ready on both sides, first-word-fall-through head, occupancy count.
module decoupled_req_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  // Flags come only from registered count, so out_ready never reaches in_ready.
  assign in_ready    = (count_q != CW'(DEPTH));
  assign out_valid   = (count_q != '0);
  assign push        = in_valid & in_ready;
  assign pop         = out_valid & out_ready;
  assign out_data    = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AFULL_THRESH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; writes are suppressed during reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
    count_q <= CW'(DEPTH));

  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n)
    pop |-> (count_q != '0));

  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable(out_data));

endmodule

// File: tb/tb_decoupled_req_fifo.sv
// Self-checking bench: DEPTH=4 directed table plus sequences, DEPTH=3 random
// traffic, both against a queue-based scoreboard.
module tb_decoupled_req_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN4, inValid4, inReady4, outValid4, outReady4, almostFull4;
  logic [31:0] inData4, outData4;
  logic [2:0]  count4;

  logic        rstN3, inValid3, inReady3, outValid3, outReady3, almostFull3;
  logic [31:0] inData3, outData3;
  logic [1:0]  count3;

  decoupled_req_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AFULL_THRESH(3)) dut4 (
    .clk(clk), .rst_n(rstN4),
    .in_valid(inValid4), .in_ready(inReady4), .in_data(inData4),
    .out_valid(outValid4), .out_ready(outReady4), .out_data(outData4),
    .count(count4), .almost_full(almostFull4)
  );

  decoupled_req_fifo #(.DATA_WIDTH(32), .DEPTH(3), .AFULL_THRESH(2)) dut3 (
    .clk(clk), .rst_n(rstN3),
    .in_valid(inValid3), .in_ready(inReady3), .in_data(inData3),
    .out_valid(outValid3), .out_ready(outReady3), .out_data(outData3),
    .count(count3), .almost_full(almostFull3)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    int          eCount;
    logic        eInReady;
    logic        eAfull;
    logic        eOutValid;
    logic [31:0] eData;
    logic        chkData;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] q4[$];
  logic [31:0] q3[$];
  int          nChecks = 0;
  int          nFails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle on the DEPTH=4 instance from a negedge; the scoreboard
  // decides acceptance from its own occupancy and checks popped data.
  task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] d, input logic r);
    logic        doPush, doPop;
    logic [31:0] exp;
    rstN4 = rst; inValid4 = v; inData4 = d; outReady4 = r;
    #1;
    checkOutput("in_ready", 32'(inReady4), 32'(q4.size() != 4));
    checkOutput("out_valid", 32'(outValid4), 32'(q4.size() != 0));
    doPush = rst && v && (q4.size() != 4);
    doPop  = rst && r && (q4.size() != 0);
    if (doPop) begin
      exp = q4.pop_front();
      checkOutput("pop_data", outData4, exp);
    end
    if (!rst) q4.delete();
    else if (doPush) q4.push_back(d);
    @(posedge clk);
    @(negedge clk);
    checkOutput("count", 32'(count4), 32'(q4.size()));
    checkOutput("almost_full", 32'(almostFull4), 32'(q4.size() >= 3));
  endtask

  initial begin
    logic        v, r, doPush, doPop;
    logic [31:0] d, exp;

    // Push A0..A4 with consumer stalled, then drain with consumer ready.
    tbl[0] = '{1'b1, 32'hA0, 1'b0, 1, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b1};
    tbl[1] = '{1'b1, 32'hA1, 1'b0, 2, 1'b1, 1'b0, 1'b1, 32'hA0, 1'b1};
    tbl[2] = '{1'b1, 32'hA2, 1'b0, 3, 1'b1, 1'b1, 1'b1, 32'hA0, 1'b1};
    tbl[3] = '{1'b1, 32'hA3, 1'b0, 4, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b1};
    tbl[4] = '{1'b1, 32'hA4, 1'b0, 4, 1'b0, 1'b1, 1'b1, 32'hA0, 1'b1};
    tbl[5] = '{1'b0, 32'h00, 1'b1, 3, 1'b1, 1'b1, 1'b1, 32'hA1, 1'b1};
    tbl[6] = '{1'b0, 32'h00, 1'b1, 2, 1'b1, 1'b0, 1'b1, 32'hA2, 1'b1};
    tbl[7] = '{1'b0, 32'h00, 1'b1, 1, 1'b1, 1'b0, 1'b1, 32'hA3, 1'b1};
    tbl[8] = '{1'b0, 32'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0};
    tbl[9] = '{1'b0, 32'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0};

    rstN4 = 1'b0; inValid4 = 1'b0; inData4 = '0; outReady4 = 1'b0;
    rstN3 = 1'b0; inValid3 = 1'b0; inData3 = '0; outReady3 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN3 = 1'b1;

    $display("[TB] reset then idle");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("idle_in_ready", 32'(inReady4), 32'd1);
      checkOutput("idle_out_valid", 32'(outValid4), 32'd0);
    end

    $display("[TB] fill and drain table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, tbl[i].v, tbl[i].d, tbl[i].r);
      checkOutput($sformatf("tbl%0d_count", i), 32'(count4), 32'(tbl[i].eCount));
      checkOutput($sformatf("tbl%0d_in_ready", i), 32'(inReady4), 32'(tbl[i].eInReady));
      checkOutput($sformatf("tbl%0d_afull", i), 32'(almostFull4), 32'(tbl[i].eAfull));
      checkOutput($sformatf("tbl%0d_out_valid", i), 32'(outValid4), 32'(tbl[i].eOutValid));
      if (tbl[i].chkData) checkOutput($sformatf("tbl%0d_out_data", i), outData4, tbl[i].eData);
    end

    $display("[TB] streaming with pointer wrap");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h10 + 32'(i), 1'b1);
      checkOutput("stream_count", 32'(count4), 32'd1);
      checkOutput("stream_head", outData4, 32'h10 + 32'(i));
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("stream_drained", 32'(outValid4), 32'd0);

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 1'b1, 32'h30, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h31, 1'b0);
    checkOutput("pre_reset_count", 32'(count4), 32'd2);
    applyStimulus(1'b0, 1'b1, 32'h32, 1'b1);
    checkOutput("post_reset_count", 32'(count4), 32'd0);
    checkOutput("post_reset_out_valid", 32'(outValid4), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h55, 1'b0);
    checkOutput("after_reset_head", outData4, 32'h55);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("after_reset_empty", 32'(outValid4), 32'd0);

    $display("[TB] DEPTH=3 random traffic");
    for (int i = 0; i < 1000; i++) begin
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom;
      inValid3 = v; inData3 = d; outReady3 = r;
      #1;
      checkOutput("d3_in_ready", 32'(inReady3), 32'(q3.size() != 3));
      checkOutput("d3_out_valid", 32'(outValid3), 32'(q3.size() != 0));
      doPush = v && (q3.size() != 3);
      doPop  = r && (q3.size() != 0);
      if (doPop) begin
        exp = q3.pop_front();
        checkOutput("d3_pop_data", outData3, exp);
      end
      if (doPush) q3.push_back(d);
      @(posedge clk);
      @(negedge clk);
      checkOutput("d3_count", 32'(count3), 32'(q3.size()));
      checkOutput("d3_afull", 32'(almostFull3), 32'(q3.size() >= 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
